rx_fifo: RTL

Receive-side byte buffer sitting directly downstream of the UART receiver (`rxblock`). It synchronises the receiver's `receive_flag` level into the `clk16` domain, captures the byte on `para_data_out` once per new frame, and stores it in a small circular FIFO. The host side drains the FIFO through a pop handshake. Full, empty, occupancy and a sticky overrun flag are reported.

---
 rtl/rx_fifo.sv | 75 +++++++
 1 files changed

// File: rtl/rx_fifo.sv
// Receive byte FIFO behind the UART receiver: synchronises receive_flag,
// captures one byte per frame and buffers it for the host pop interface.
module rx_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk16,
  input  logic          rst_n,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  input  logic          rd_en,
  input  logic          clr_overrun,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overrun
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  logic [2:0]          sync_q;   // [0]=s1, [1]=s2, [2]=s3
  logic [DEPTH-1:0][7:0] mem;
  logic [AW-1:0]       wp, rp;
  logic                push, pop, push_ok, drop;
  logic [AW:0]         count_nxt;

  assign push    = sync_q[1] & ~sync_q[2];
  assign pop     = rd_en & ~empty;
  assign push_ok = push & (~full | pop);
  assign drop    = push & full & ~pop;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop)      count_nxt = count + ONE;
    else if (pop && !push_ok) count_nxt = count - ONE;
  end

  // Sync chain resets high so a level already asserted at release is not a new frame.
  always_ff @(posedge clk16) begin
    if (!rst_n) sync_q <= 3'b111;
    else        sync_q <= {sync_q[1:0], rx_valid};
  end

  always_ff @(posedge clk16) begin
    if (push_ok) mem[wp] <= rx_data;
  end

  always_ff @(posedge clk16) begin
    if (!rst_n) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      rd_data  <= 8'h00;
      rd_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      count    <= count_nxt;
      rd_valid <= pop;
      if (push_ok) wp <= wp + AW'(1);
      if (pop) begin
        rd_data <= mem[rp];
        rp      <= rp + AW'(1);
      end
      if (drop)             overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

endmodule
